// File: rtl/gpu_frame_sequencer.sv
// rtl/gpu_frame_sequencer.sv - per-frame clear/draw sequencer between CPU descriptors and the gpu draw engine
module gpu_frame_sequencer #(
  parameter int DEPTH     = 4,
  parameter int DRAIN_MIN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [143:0] req_desc,
  input  logic         frame_go,
  input  logic         clear_en,
  input  logic [15:0]  clear_color,
  output logic         busy,
  output logic         frame_done,
  output logic [31:0]  ctrl_address,
  output logic [15:0]  ctrl_address_x,
  output logic [15:0]  ctrl_address_y,
  output logic [15:0]  ctrl_sheetsize,
  output logic [15:0]  ctrl_width,
  output logic [15:0]  ctrl_height,
  output logic [15:0]  ctrl_x,
  output logic [15:0]  ctrl_y,
  output logic         ctrl_draw,
  output logic         ctrl_clear,
  output logic [15:0]  ctrl_clear_color,
  input  logic         ctrl_full,
  input  logic         gpu_idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DRAIN_MIN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_REQ, S_CLR_WAIT, S_ISSUE, S_HOLD, S_DRAIN
  } state_t;

  // Descriptor FIFO storage and pointers
  logic [143:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;
  logic [143:0]  head;

  // Sequencer state
  state_t        state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [15:0]   clr_color_q, clr_color_d;
  logic          hold_q, hold_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          draw_q, draw_d;
  logic          done_q, done_d;

  // Draw parameters presented to the GPU
  logic [31:0]   address_q;
  logic [15:0]   address_x_q, address_y_q, sheetsize_q, width_q, height_q, x_q, y_q;

  assign req_ready = (count_q != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];

  // FIFO payload write; contents need no reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_desc;
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Sequencer next-state; a strobe is decided in ISSUE and appears registered the next cycle
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    clr_color_d = clr_color_q;
    hold_d      = hold_q;
    drain_cnt_d = (drain_cnt_q == DW'(DRAIN_MIN)) ? drain_cnt_q : drain_cnt_q + DW'(1);
    draw_d      = 1'b0;
    done_d      = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_go) begin
          clr_color_d = clear_color;
          remaining_d = count_q;
          drain_cnt_d = '0;
          state_d     = clear_en ? S_CLR_REQ : S_ISSUE;
        end
      end
      S_CLR_REQ:  if (!gpu_idle) state_d = S_CLR_WAIT;
      S_CLR_WAIT: if (gpu_idle)  state_d = S_ISSUE;
      S_ISSUE: begin
        if (remaining_q == '0) begin
          state_d = S_DRAIN;
        end else if (!ctrl_full) begin
          pop         = 1'b1;
          draw_d      = 1'b1;
          remaining_d = remaining_q - CW'(1);
          drain_cnt_d = '0;
          hold_d      = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        hold_d = 1'b1;
        if (hold_q) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if ((drain_cnt_q == DW'(DRAIN_MIN)) && gpu_idle) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      clr_color_q <= '0;
      hold_q      <= 1'b0;
      drain_cnt_q <= '0;
      draw_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      clr_color_q <= clr_color_d;
      hold_q      <= hold_d;
      drain_cnt_q <= drain_cnt_d;
      draw_q      <= draw_d;
      done_q      <= done_d;
    end
  end

  // Draw parameter latch: loaded from the FIFO head on pop, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      address_q   <= '0;
      address_x_q <= '0;
      address_y_q <= '0;
      sheetsize_q <= '0;
      width_q     <= '0;
      height_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
    end else if (pop) begin
      address_q   <= head[143:112];
      address_x_q <= head[111:96];
      address_y_q <= head[95:80];
      sheetsize_q <= head[79:64];
      width_q     <= head[63:48];
      height_q    <= head[47:32];
      x_q         <= head[31:16];
      y_q         <= head[15:0];
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign frame_done       = done_q;
  assign ctrl_draw        = draw_q;
  assign ctrl_clear       = (state_q == S_CLR_REQ);
  assign ctrl_clear_color = clr_color_q;
  assign ctrl_address     = address_q;
  assign ctrl_address_x   = address_x_q;
  assign ctrl_address_y   = address_y_q;
  assign ctrl_sheetsize   = sheetsize_q;
  assign ctrl_width       = width_q;
  assign ctrl_height      = height_q;
  assign ctrl_x           = x_q;
  assign ctrl_y           = y_q;

endmodule

// File: doc/gpu_frame_sequencer.md
# gpu_frame_sequencer

Per-frame controller that sits between the CPU-side register interface and the `gpu` draw engine. It buffers draw descriptors from the CPU and, on a frame start, sequences an optional framebuffer clear followed by the buffered draw calls. Each draw call is presented on the GPU `ctrl_*` bus with the required hold time and `ctrl_full` back-pressure. When the GPU has drained, the block signals frame completion.

## Interface
- `DEPTH`, 4: descriptor buffer slots (power of two, ≥2)
- `DRAIN_MIN`, 4: minimum cycles after the last draw pulse before `gpu_idle` is trusted

- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  1  descriptor offered
- `req_ready`  out  1  descriptor buffer not full
- `req_desc`  in  144  {addr[31:0], addr_x, addr_y, sheetsize, width, height, x, y} (16 b each), MSB first
- `frame_go`  in  1  single-cycle frame start request
- `clear_en`  in  1  clear framebuffer this frame; sampled with `frame_go`
- `clear_color`  in  16  clear colour; sampled with `frame_go`
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse at frame end
- `ctrl_address`  out  32  to GPU
- `ctrl_address_x`, `ctrl_address_y`, `ctrl_sheetsize`, `ctrl_width`, `ctrl_height`, `ctrl_x`, `ctrl_y`  out  16 each  to GPU
- `ctrl_draw`  out  1  draw strobe to GPU
- `ctrl_clear`  out  1  clear request to GPU
- `ctrl_clear_color`  out  16  to GPU
- `ctrl_full`  in  1  GPU render queue full
- `gpu_idle`  in  1  GPU in IDLE with an empty queue

## Operation
- **Descriptor FIFO:** `DEPTH` entries. Push when `req_valid && req_ready`, at any time, including mid-frame. `req_ready = !full`. A push and a pop in the same cycle leave occupancy unchanged.
- **Frame snapshot:** on `frame_go` in IDLE, latch `clear_en`, `clear_color` and `remaining` = current FIFO occupancy ($clog2(DEPTH+1) bits). Only those descriptors belong to the frame. Later pushes wait for the next frame.
- `frame_go` outside IDLE is ignored. It is not queued.
- **States:**
  - **IDLE:** `busy = 0`. On `frame_go`, go to CLR_REQ if `clear_en`, else ISSUE.
  - **CLR_REQ:** `ctrl_clear = 1`, `ctrl_clear_color` = latched colour. Stay until `gpu_idle = 0` (the GPU has taken the clear), then drop `ctrl_clear` and go to CLR_WAIT.
  - **CLR_WAIT:** wait for `gpu_idle = 1`, then go to ISSUE.
  - **ISSUE:**
    - If `remaining == 0`, go to DRAIN.
    - Else, if `ctrl_full = 0`, load the FIFO head onto `ctrl_*`, assert `ctrl_draw`, pop the FIFO, decrement `remaining`, and go to HOLD.
    - If `ctrl_full = 1`, wait with `ctrl_draw = 0`.
  - **HOLD:** two cycles with `ctrl_draw = 0` and `ctrl_*` unchanged, then return to ISSUE.
  - **DRAIN:** wait at least `DRAIN_MIN` cycles after the last `ctrl_draw` pulse (counter), then wait for `gpu_idle = 1`. Then pulse `frame_done` and go to IDLE.
- A frame with zero descriptors and no clear goes IDLE → ISSUE → DRAIN and completes once the `DRAIN_MIN` counter (started at entry) and `gpu_idle` allow.
- `ctrl_*` retain their last values outside HOLD/ISSUE; the GPU ignores them without a strobe.

## Timing
- **Reset:** all outputs 0, FIFO empty, state IDLE, `remaining = 0`. Reset mid-frame aborts immediately. In-flight GPU work is not the sequencer's concern.
- **Start latency:** `busy` rises the cycle after `frame_go`.
- **Clear start:** `ctrl_clear` rises the cycle after `frame_go` when `clear_en = 1`.
- **Draw strobe and hold:** `ctrl_draw` is high for exactly 1 cycle (T0). `ctrl_*` are valid at T0 and stable through T0+2.
- **Draw spacing:** the next strobe is no earlier than T0+3, so minimum draw spacing is 3 cycles and `ctrl_draw` is always low between strobes (rising-edge detect in the GPU).
- **Back-pressure:** `ctrl_full` is sampled only in ISSUE, in the cycle before the strobe. A strobe is never issued while `ctrl_full = 1`.
- **`frame_done`:** one cycle, coincident with the transition to IDLE. `busy` falls in the same cycle.
- **FIFO timing:** `req_ready` is combinational from occupancy only and is never a function of `req_valid`.

## Test plan
- **Basic frame:** reset, push 2 descriptors (x = 10, y = 20 and x = 30, y = 40), pulse `frame_go` with `clear_en = 0`; `gpu_idle` is modelled by a GPU stub → exactly 2 one-cycle `ctrl_draw` pulses spaced ≥3 cycles, `ctrl_x`/`ctrl_y` stable for 3 cycles each, then one `frame_done`.
- **Clear then draw:** `clear_en = 1`, `clear_color = 0xF800`, 1 descriptor; the stub drops `gpu_idle` 2 cycles after `ctrl_clear` and holds it low for 50 cycles → `ctrl_clear` is high until `gpu_idle` falls, and the first `ctrl_draw` comes after `gpu_idle` returns to 1.
- **Back-pressure:** hold `ctrl_full = 1` for 20 cycles during a frame with 3 descriptors → no `ctrl_draw` while full, and all 3 descriptors are issued after release, in FIFO order.
- **Full FIFO and snapshot:** push `DEPTH` descriptors → `req_ready = 0`. Start the frame and push 1 more once ready → only `DEPTH` draws occur that frame, and the extra one is issued in the next frame.
- **Empty frame and ignored start:** `frame_go` with an empty FIFO and no clear → `frame_done` after `DRAIN_MIN` cycles and `gpu_idle`. A second `frame_go` while `busy = 1` → ignored, only one `frame_done`.
- **Reset mid-frame:** assert `rst` during HOLD → the next cycle shows all outputs 0, `req_ready = 1`, and no further draws.
